// File: rtl/leb128_encoder_if.sv
// Request and byte-stream handshake bundle for the LEB128 encoder.
// master drives requests and sink readiness; slave is the encoder itself.
interface leb128_encoder_if #(
  parameter int DW = 64,
  parameter int CW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_value;
  logic          in_signed;
  logic          in_is64;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_byte;
  logic          out_last;
  logic [CW-1:0] byte_count;

  modport master (
    output in_valid, in_value, in_signed, in_is64, out_ready,
    input  in_ready, out_valid, out_byte, out_last, byte_count
  );

  modport slave (
    input  in_valid, in_value, in_signed, in_is64, out_ready,
    output in_ready, out_valid, out_byte, out_last, byte_count
  );
endinterface

// File: rtl/leb128_encoder.sv
// Streams a 32/64-bit integer as ULEB128/SLEB128 bytes; first byte one cycle after acceptance.
// Bytes are back-to-back under out_ready; everything holds while out_ready is low, one bubble after the last byte.
module leb128_encoder #(
  parameter int DW = 64,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            reset,
  leb128_encoder_if.slave bus
);
  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state, state_next;
  logic [DW-1:0] w, w_next;
  logic          sgn, sgn_next;
  logic          is64, is64_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [7:0]    obyte, obyte_next;
  logic          olast, olast_next;
  logic          ovalid, ovalid_next;
  logic [DW-1:0] w_ext;
  logic [8:0]    enc;

  function automatic logic [DW-1:0] shr7(input logic [DW-1:0] v, input logic s);
    logic [DW-1:0] r;
    if (s) r = $signed(v) >>> 7;
    else   r = v >> 7;
    return r;
  endfunction

  // Returns {last, byte}; the count check caps runaway encodings at the legal maximum length.
  function automatic logic [8:0] gen(input logic [DW-1:0] v, input logic s,
                                     input logic b64, input logic [CW-1:0] c);
    logic [DW-1:0] rest;
    logic          done;
    logic          cap;
    rest = shr7(v, s);
    if (s) done = ((rest == '0) && !v[6]) || ((&rest) && v[6]);
    else   done = (rest == '0);
    cap  = b64 ? (c == CW'(9)) : (c == CW'(4));
    done = done | cap;
    return {done, ~done, v[6:0]};
  endfunction

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = ovalid;
  assign bus.out_byte   = obyte;
  assign bus.out_last   = olast;
  assign bus.byte_count = cnt;

  always_comb begin
    if (bus.in_signed) w_ext = {{(DW-32){bus.in_value[31]}}, bus.in_value[31:0]};
    else               w_ext = {{(DW-32){1'b0}}, bus.in_value[31:0]};
    if (bus.in_is64)   w_ext = bus.in_value;
  end

  always_comb begin
    state_next  = state;
    w_next      = w;
    sgn_next    = sgn;
    is64_next   = is64;
    cnt_next    = cnt;
    obyte_next  = obyte;
    olast_next  = olast;
    ovalid_next = ovalid;
    enc         = '0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          enc         = gen(w_ext, bus.in_signed, bus.in_is64, '0);
          w_next      = w_ext;
          sgn_next    = bus.in_signed;
          is64_next   = bus.in_is64;
          cnt_next    = '0;
          obyte_next  = enc[7:0];
          olast_next  = enc[8];
          ovalid_next = 1'b1;
          state_next  = EMIT;
        end
      end
      EMIT: begin
        if (ovalid && bus.out_ready) begin
          cnt_next = cnt + CW'(1);
          if (olast) begin
            ovalid_next = 1'b0;
            state_next  = IDLE;
          end else begin
            enc        = gen(shr7(w, sgn), sgn, is64, cnt + CW'(1));
            w_next     = shr7(w, sgn);
            obyte_next = enc[7:0];
            olast_next = enc[8];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      w      <= '0;
      sgn    <= 1'b0;
      is64   <= 1'b0;
      cnt    <= '0;
      obyte  <= 8'h00;
      olast  <= 1'b0;
      ovalid <= 1'b0;
    end else begin
      state  <= state_next;
      w      <= w_next;
      sgn    <= sgn_next;
      is64   <= is64_next;
      cnt    <= cnt_next;
      obyte  <= obyte_next;
      olast  <= olast_next;
      ovalid <= ovalid_next;
    end
  end
endmodule

// File: tb/tb_leb128_encoder.sv
// Randomised and directed checks of leb128_encoder against a fits-in-N-bits LEB128 model.
module tb_leb128_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  leb128_encoder_if #(.DW(64), .CW(4)) bus ();
  leb128_encoder #(.DW(64), .CW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  logic [7:0] got_b[$];
  bit         got_l[$];
  int         got_c[$];
  logic [7:0] stall_seen[$];
  int         first_lat, last_acc, wait_cyc, inrdy_bad;
  bit         timeout;
  logic       post_ready, post_valid;
  int         post_cnt;

  function automatic logic [127:0] ref_ext(logic [63:0] v, bit s, bit i64);
    logic [63:0] op;
    if (i64)    op = v;
    else if (s) op = {{32{v[31]}}, v[31:0]};
    else        op = {32'b0, v[31:0]};
    return s ? {{64{op[63]}}, op} : {64'b0, op};
  endfunction

  // Minimal byte count: smallest 7k-bit field that represents the value exactly.
  function automatic int ref_len(logic [127:0] x, bit s);
    logic [127:0] t;
    for (int k = 1; k <= 10; k++) begin
      if (s) begin
        t = $signed(x) >>> (7*k-1);
        if (t == '0 || &t) return k;
      end else if ((x >> (7*k)) == '0) return k;
    end
    return 11;
  endfunction

  function automatic logic [7:0] ref_byte(logic [127:0] x, int i, int n);
    logic [127:0] t;
    t = x >> (7*i);
    return {(i < n-1) ? 1'b1 : 1'b0, t[6:0]};
  endfunction

  task automatic encode(input logic [63:0] v, input bit s, input bit i64,
                        input int stall_pct, input int stall_idx, input int stall_len);
    int cyc, stall_ctr, idx;
    bit done;
    got_b.delete(); got_l.delete(); got_c.delete(); stall_seen.delete();
    timeout = 0; inrdy_bad = 0; first_lat = -1; wait_cyc = 0; done = 0;
    bus.in_valid = 1'b1; bus.in_value = v; bus.in_signed = s; bus.in_is64 = i64;
    while (!bus.in_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (wait_cyc >= 50) timeout = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_value = {$urandom, $urandom};
    bus.in_signed = 1'($urandom);
    bus.in_is64 = 1'($urandom);
    cyc = 1; stall_ctr = 0;
    while (!done && cyc < 300 && !timeout) begin
      if (bus.in_ready) inrdy_bad++;
      if (bus.out_valid) begin
        if (first_lat < 0) first_lat = cyc;
        idx = got_b.size();
        if (idx == stall_idx && stall_ctr < stall_len) begin
          bus.out_ready = 1'b0;
          stall_seen.push_back(bus.out_byte);
          stall_ctr++;
        end else bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
        if (bus.out_ready) begin
          got_b.push_back(bus.out_byte);
          got_l.push_back(bus.out_last);
          got_c.push_back(int'(bus.byte_count));
          if (bus.out_last) done = 1;
        end
      end else bus.out_ready = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    if (!done) timeout = 1;
    last_acc = cyc - 1;
    bus.out_ready = 1'b1;
    post_ready = bus.in_ready;
    post_valid = bus.out_valid;
    post_cnt = int'(bus.byte_count);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_value = '0; bus.in_signed = 1'b0; bus.in_is64 = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    nvec++; if (bus.out_byte !== 8'h00) begin nerr++; $display("FAIL reset_out_byte: got %h expected 00", bus.out_byte); end
    nvec++; if (bus.out_last !== 1'b0) begin nerr++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
    nvec++; if (bus.byte_count !== 4'd0) begin nerr++; $display("FAIL reset_byte_count: got %0d expected 0", bus.byte_count); end
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [63:0] tv[9]  = '{64'd624485, 64'hDEADBEEF_FFFE1DC0, 64'h40, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF, 64'h8000_0000};
    bit          ts[9]  = '{0, 1, 1, 0, 1, 0, 1, 0, 1};
    bit          t64[9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
    int          tn[9]  = '{3, 3, 2, 1, 1, 10, 10, 5, 5};
    logic [79:0] te[9]  = '{80'h268EE5, 80'h78BBC0, 80'h00C0, 80'h00, 80'h7F,
                            80'h01FFFFFFFFFFFFFFFFFF, 80'h7F808080808080808080,
                            80'h0FFFFFFFFF, 80'h7880808080};
    logic [79:0] sh;
    for (int t = 0; t < 9; t++) begin
      encode(tv[t], ts[t], t64[t], 0, -1, 0);
      nvec++; if (timeout || got_b.size() != tn[t]) begin nerr++; $display("FAIL dir%0d_len: got %0d bytes expected %0d", t, got_b.size(), tn[t]); end
      nvec++; if (ref_len(ref_ext(tv[t], ts[t], t64[t]), ts[t]) != tn[t]) begin nerr++; $display("FAIL dir%0d_model_len: got %0d expected %0d", t, ref_len(ref_ext(tv[t], ts[t], t64[t]), ts[t]), tn[t]); end
      nvec++; if (first_lat != 1) begin nerr++; $display("FAIL dir%0d_latency: got %0d expected 1", t, first_lat); end
      nvec++; if (post_cnt != tn[t]) begin nerr++; $display("FAIL dir%0d_final_count: got %0d expected %0d", t, post_cnt, tn[t]); end
      for (int i = 0; i < got_b.size() && i < tn[t]; i++) begin
        sh = te[t] >> (8*i);
        nvec++; if (got_b[i] !== sh[7:0] || got_l[i] != (i == tn[t]-1) || got_c[i] != i) begin
          nerr++; $display("FAIL dir%0d_byte%0d: got %h last %0d cnt %0d expected %h last %0d cnt %0d",
                           t, i, got_b[i], got_l[i], got_c[i], sh[7:0], (i == tn[t]-1), i);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0]  v;
    logic [127:0] x;
    bit s, i64;
    int n, bad;
    for (int it = 0; it < 250; it++) begin
      v = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) v = ~v;
      s = 1'($urandom); i64 = 1'($urandom);
      x = ref_ext(v, s, i64);
      n = ref_len(x, s);
      encode(v, s, i64, 30, -1, 0);
      bad = 0;
      if (timeout || got_b.size() != n) bad = 1;
      else for (int i = 0; i < n; i++)
        if (got_b[i] !== ref_byte(x, i, n) || got_l[i] != (i == n-1) || got_c[i] != i) bad = 1;
      nvec++; if (bad != 0) begin nerr++; $display("FAIL rand%0d v=%h s=%0d i64=%0d: got %0d bytes first %h expected %0d bytes first %h", it, v, s, i64, got_b.size(), (got_b.size() > 0) ? got_b[0] : 8'hxx, n, ref_byte(x, 0, n)); end
      nvec++; if (n > (i64 ? 10 : 5) || post_cnt != n || inrdy_bad != 0) begin nerr++; $display("FAIL rand%0d_bounds: got count %0d in_ready_hi %0d expected count %0d in_ready_hi 0", it, post_cnt, inrdy_bad, n); end
    end
  endtask

  task automatic test_backpressure();
    encode(64'd624485, 0, 0, 0, 1, 3);
    nvec++; if (stall_seen.size() != 3) begin nerr++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall_seen.size()); end
    for (int i = 0; i < stall_seen.size(); i++) begin
      nvec++; if (stall_seen[i] !== 8'h8E) begin nerr++; $display("FAIL bp_hold%0d: got %h expected 8e", i, stall_seen[i]); end
    end
    nvec++; if (inrdy_bad != 0) begin nerr++; $display("FAIL bp_in_ready: got %0d busy cycles with in_ready=1 expected 0", inrdy_bad); end
    nvec++; if (timeout || got_b.size() != 3 || got_b[0] !== 8'hE5 || got_b[1] !== 8'h8E || got_b[2] !== 8'h26)
      begin nerr++; $display("FAIL bp_sequence: got %0d bytes expected e5 8e 26", got_b.size()); end
  endtask

  task automatic test_back_to_back();
    encode(64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, -1, 0);
    nvec++; if (last_acc != 10) begin nerr++; $display("FAIL b2b_stream_cycles: got %0d expected 10", last_acc); end
    nvec++; if (post_ready !== 1'b1 || post_valid !== 1'b0) begin nerr++; $display("FAIL b2b_bubble: got in_ready %b out_valid %b expected 1 0", post_ready, post_valid); end
    encode(64'd300, 0, 0, 0, -1, 0);
    nvec++; if (wait_cyc != 0 || first_lat != 1) begin nerr++; $display("FAIL b2b_reaccept: got wait %0d latency %0d expected 0 1", wait_cyc, first_lat); end
    nvec++; if (got_b.size() != 2 || got_b[0] !== 8'hAC || got_b[1] !== 8'h02) begin nerr++; $display("FAIL b2b_second: got %0d bytes expected ac 02", got_b.size()); end
  endtask

  task automatic test_reset_midstream();
    int stray;
    bus.in_valid = 1'b1; bus.in_value = '1; bus.in_signed = 1'b0; bus.in_is64 = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL rst_mid_out_valid: got %b expected 0", bus.out_valid); end
    nvec++; if (bus.byte_count !== 4'd0) begin nerr++; $display("FAIL rst_mid_byte_count: got %0d expected 0", bus.byte_count); end
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus.in_ready); end
    stray = 0;
    repeat (3) begin @(negedge clk); if (bus.out_valid) stray++; end
    nvec++; if (stray != 0) begin nerr++; $display("FAIL rst_mid_stray: got %0d valid cycles expected 0", stray); end
    encode(64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, -1, 0);
    nvec++; if (timeout || got_b.size() != 1 || got_b[0] !== 8'h7F || got_l[0] != 1)
      begin nerr++; $display("FAIL rst_mid_next: got %0d bytes expected single 7f with last", got_b.size()); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_value = '0; bus.in_signed = 1'b0; bus.in_is64 = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/leb128_encoder.md
Name: leb128_encoder

Overview:
Streams a 32- or 64-bit integer out as WebAssembly LEB128 bytecode, one byte per handshake, in both unsigned (ULEB128) and signed (SLEB128) forms. It is the encoding counterpart of the core's immediate decoder. Uses: emitting `i32.const`/`i64.const` immediates into generated test ROM images, and serializing `result` values back into bytecode form.
- Input side: `valid/ready` handshake.
- Output side: byte stream with `valid/ready` handshake and a last-byte marker.

Parameters:
- `DW`, 64: maximum input value width in bits. Only 64 is supported.
- `CW`, 4: width of the byte counter. Must satisfy `2**CW > ceil(DW/7)`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  an encode request is presented.
- `in_ready`  out  1  block is able to accept a request.
- `in_value`  in  64  value to encode.
- `in_signed`  in  1  1 = SLEB128, 0 = ULEB128.
- `in_is64`  in  1  1 = 64-bit operand (i64), 0 = 32-bit operand (i32; bits 63:32 of `in_value` are ignored).
- `out_valid`  out  1  `out_byte` holds a valid byte.
- `out_ready`  in  1  sink accepts `out_byte`.
- `out_byte`  out  8  encoded byte; bit 7 is the continuation flag.
- `out_last`  out  1  the current byte is the final byte of the encoding.
- `byte_count`  out  CW  number of bytes of the current encoding already accepted by the sink.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high and has priority over every other input.
- Reset values:
  - `out_valid` = 0, `out_byte` = 0x00, `out_last` = 0, `byte_count` = 0.
  - State = IDLE, so `in_ready` = 1 on the first cycle after reset.
- States: IDLE and EMIT. `in_ready` = (state == IDLE) and is decoded from state only.
- IDLE, when `in_valid` && `in_ready`:
  - Latch a 64-bit working register `w`.
  - `in_is64` = 0: `w` = `in_value[31:0]`, sign-extended if `in_signed`, else zero-extended.
  - `in_is64` = 1: `w` = `in_value`.
  - Latch `in_signed` into `sgn`. Clear `byte_count`. Go to EMIT.
- Latency: the first byte appears with `out_valid` = 1 on the cycle after acceptance.
- Byte generation in EMIT, combinational from `w` into registered outputs:
  - `rest` = `w >> 7`. Shift is arithmetic if `sgn`, logical otherwise.
  - Unsigned: `done` = (`rest` == 0).
  - Signed: `done` = (`rest` == 0 && `w[6]` == 0) || (`rest` == all-ones && `w[6]` == 1).
  - `out_byte` = {~`done`, `w[6:0]`}; `out_last` = `done`.
- Output hold rule: while `out_valid` && !`out_ready`, `out_byte`, `out_last`, `w` and `byte_count` all hold.
- On `out_valid` && `out_ready`:
  - `byte_count` increments.
  - If `out_last`: `out_valid` drops to 0 and the state returns to IDLE. There is one bubble cycle, so a new request is accepted at the earliest on the next cycle.
  - Otherwise: `w` <= `rest` and the next byte is presented on the following cycle, giving back-to-back bytes with no bubble.
- Byte-count bounds: at most 5 bytes for 32-bit operands and 10 bytes for 64-bit operands.
  - A safety terminator forces `out_last` = 1 with bit 7 = 0 when `byte_count` == 4 (32-bit) or 9 (64-bit).
  - This must never change the result for legal inputs. The bench cross-checks it.
- Request inputs in EMIT: `in_value`, `in_signed` and `in_is64` are ignored. No request is lost, because `in_ready` = 0.
- `byte_count` after completion: holds the final count while in IDLE until the next acceptance.
- Reset mid-stream: the encoding is discarded. The next cycle shows the reset values, and no partial continuation follows.
- Zero and minus-one: 0 → 0x00. Signed −1 → 0x7F. Each is a single byte with `out_last` = 1.

Test Plan:
- u32, `in_value` = 624485, `out_ready` = 1 → E5 8E 26.
  - `out_last` only on 0x26; `byte_count` ends at 3.
  - `out_valid` first rises 1 cycle after acceptance.
- i32, `in_value` = 0xDEADBEEF_FFFE1DC0 (−123456 in the low word; upper bits garbage) → C0 BB 78, 3 bytes.
- i32, `in_value` = 0x0000_0000_0000_0040 (+64) → C0 00. Also u32 0 → 00 and i64 −1 → 7F, each 1 byte with `out_last` = 1.
- u64, `in_value` = 0xFFFFFFFFFFFFFFFF → FF ×9 then 01, 10 bytes. Also i64 0x8000000000000000 → 80 ×9 then 7F.
- Backpressure: encode u32 624485 and hold `out_ready` = 0 for 3 cycles while 0x8E is presented.
  - 0x8E stays stable across those cycles.
  - `in_ready` stays 0 throughout the encoding.
  - The full sequence is E5 8E 26, unchanged.
- Reset mid-stream: assert `reset` after the first byte of the u64 all-ones encoding.
  - Next cycle: `out_valid` = 0, `byte_count` = 0, `in_ready` = 1.
  - A following i64 −1 request yields a single 7F.
